// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Writable 16 x 8 program store fed by a valid/ready host
//                stream; holds the CPU in reset while a program loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic [3:0] pc,
    output logic [3:0] a,
    output logic [3:0] d,
    output logic       cpu_rst_n,
    output logic       done,
    output logic [4:0] count,
    output logic       err
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [4:0] c_LAST_IDX = 5'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_AW-1:0]   r_wptr;
    logic [4:0]        r_count;
    logic              r_err;
    logic [7:0]        r_mem [DEPTH];

    logic              w_xfer;
    logic [7:0]        w_word;

    assign w_xfer = in_valid && (r_state == S_LOAD);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    // A (re)load wipes the whole store so stale words never leak into a shorter program.
                    if (start) begin
                        r_state <= S_LOAD;
                        r_wptr  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) begin
                            r_mem[i] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_mem[r_wptr] <= in_data;
                        r_wptr        <= r_wptr + 1'b1;
                        r_count       <= r_count + 5'd1;
                        if (in_last) begin
                            r_state <= S_RUN;
                        end else if (r_count == c_LAST_IDX) begin
                            r_state <= S_RUN;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign cpu_rst_n = (r_state == S_RUN);
    assign done      = (r_state == S_RUN);
    assign count     = r_count;
    assign err       = r_err;

    assign w_word = r_mem[pc];
    assign a      = w_word[7:4];
    assign d      = w_word[3:0];

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic [3:0] pc = 4'd0;
    logic [3:0] a;
    logic [3:0] d;
    logic       cpu_rst_n;
    logic       done;
    logic [4:0] count;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    prog_loader #(.DEPTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .pc        (pc),
        .a         (a),
        .d         (d),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .count     (count),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    // Model: the program is just the list of words accepted since the last clear.
    logic [7:0] m_prog [$];
    bit         m_loading = 1'b0;
    bit         m_running = 1'b0;
    bit         m_err     = 1'b0;
    bit         m_armed   = 1'b0;

    function automatic logic [7:0] m_word(input int p);
        return (p < m_prog.size()) ? m_prog[p] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        m_armed = 1'b1;
        if (!RST) begin
            m_loading = 1'b0;
            m_running = 1'b0;
            m_err     = 1'b0;
            m_prog.delete();
        end else if (!m_loading) begin
            if (start) begin
                m_loading = 1'b1;
                m_running = 1'b0;
                m_err     = 1'b0;
                m_prog.delete();
            end
        end else if (in_valid) begin
            m_prog.push_back(in_data);
            if (in_last || m_prog.size() == 16) begin
                m_loading = 1'b0;
                m_running = 1'b1;
                m_err     = !in_last;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_armed) begin
            check("in_ready",  32'(in_ready),  32'(m_loading));
            check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_running));
            check("done",      32'(done),      32'(m_running));
            check("count",     32'(count),     32'(m_prog.size()));
            check("err",       32'(err),       32'(m_err));
            check("a",         32'(a),         32'(m_word(int'(pc)) >> 4));
            check("d",         32'(d),         32'(m_word(int'(pc)) & 8'h0F));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Offer one word and wait (bounded) until it is accepted.
    task automatic send(input logic [7:0] w, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready_timeout", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic lit_pc(input string name, input logic [3:0] p, input logic [7:0] exp);
        pc = p;
        #1;
        check(name, {24'd0, a, d}, {24'd0, exp});
    endtask

    task automatic sweep_zero(input string name);
        for (int p = 0; p < 16; p++) lit_pc(name, 4'(p), 8'h00);
    endtask

    initial begin
        // Reset then idle
        RST = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        sweep_zero("rst_mem");

        // Normal load
        pulse_start();
        send(8'h05, 1'b0);
        send(8'hC3, 1'b0);
        send(8'h81, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("norm_done", 32'(done), 32'd1);
        check("norm_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("norm_count", 32'(count), 32'd3);
        check("norm_err", 32'(err), 32'd0);
        lit_pc("norm_pc0", 4'd0, 8'h05);
        lit_pc("norm_pc1", 4'd1, 8'hC3);
        lit_pc("norm_pc2", 4'd2, 8'h81);
        lit_pc("norm_pc3", 4'd3, 8'h00);

        // Backpressure gaps
        pulse_start();
        gap(2);
        send(8'h05, 1'b0);
        gap(2);
        check("gap_count1", 32'(count), 32'd1);
        send(8'hC3, 1'b0);
        gap(2);
        check("gap_still_load", 32'(in_ready), 32'd1);
        send(8'h81, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("gap_count", 32'(count), 32'd3);
        lit_pc("gap_pc1", 4'd1, 8'hC3);
        lit_pc("gap_pc2", 4'd2, 8'h81);

        // Overlength
        pulse_start();
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
        check("ovl_err", 32'(err), 32'd1);
        check("ovl_count", 32'(count), 32'd16);
        check("ovl_in_ready", 32'(in_ready), 32'd0);
        check("ovl_done", 32'(done), 32'd1);
        lit_pc("ovl_pc15", 4'd15, 8'h1F);
        in_data = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("ovl_ignored_count", 32'(count), 32'd16);
        lit_pc("ovl_pc0", 4'd0, 8'h10);

        // Reload from RUN after a normal load
        pulse_start();
        send(8'h05, 1'b0);
        send(8'hC3, 1'b0);
        send(8'h81, 1'b1);
        in_valid = 1'b0;
        pulse_start();
        check("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        send(8'hA7, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        lit_pc("reload_pc0", 4'd0, 8'hA7);
        lit_pc("reload_pc1", 4'd1, 8'h00);
        lit_pc("reload_pc2", 4'd2, 8'h00);
        check("reload_count", 32'(count), 32'd1);
        check("reload_done", 32'(done), 32'd1);

        // Start together with a host word in RUN: start wins, word dropped
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("simul_count", 32'(count), 32'd0);
        lit_pc("simul_pc0", 4'd0, 8'h00);

        // Mid-load start ignored, then reset
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        in_valid = 1'b0;
        pulse_start();
        check("ign_start_count", 32'(count), 32'd2);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        sweep_zero("midrst_mem");

        // Random traffic; the negedge compare process checks every cycle
        for (int c = 0; c < 3000; c++) begin
            RST      = ($urandom_range(0, 99) != 0);
            start    = ($urandom_range(0, 15) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            in_last  = ($urandom_range(0, 7) == 0);
            pc       = 4'($urandom);
            tick();
        end
        RST      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
